bcd_2digit: RTL and testbench
=============================

BCD_2DIGIT -- requirements
Module: bcd_2digit

Interface
REQ-001 Parameter ACTIVE_LOW, default 0; when 1, every segment output bit SHALL be inverted (1 = segment off).
REQ-002 Parameter BLANK_LZ, default 0; when 1, a tens digit of 0 SHALL be blanked (all segments off) for inputs 0..9.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 binaryNum  input  7  unsigned binary value, 0..127.
REQ-006 dec10s  output  [0:6]  7-segment pattern for the tens digit; bit 0 = segment a, ..., bit 6 = segment g.
REQ-007 dec1s  output  [0:6]  7-segment pattern for the ones digit, with the same bit order as dec10s.

Function
REQ-008 The block SHALL split binaryNum (0..99) into tens = binaryNum / 10 and ones = binaryNum mod 10, using combinational logic (double-dabble or equivalent; no multi-cycle iteration).
REQ-009 Each digit SHALL be encoded active-high (ACTIVE_LOW=0), written as bits a..g:
- 0 = 1111110
- 1 = 0110000
- 2 = 1101101
- 3 = 1111001
- 4 = 0110011
- 5 = 1011011
- 6 = 1011111
- 7 = 1110000
- 8 = 1111111
- 9 = 1111011
REQ-010 Both outputs SHALL be registered; latency is exactly 1 clk cycle from binaryNum sampled at edge N to outputs valid after edge N.
REQ-011 A new binaryNum value SHALL be accepted every cycle; there is no handshake and no stall.
REQ-012 Overflow: for binaryNum 100..127, both dec10s and dec1s SHALL show a dash (segment g only, 0000001).
REQ-013 Boundaries SHALL be exact:
- 0 -> "00" (or blank/"0" when BLANK_LZ=1)
- 9 -> "09"
- 10 -> "10"
- 99 -> "99"
- 100 -> "--"
REQ-014 ACTIVE_LOW inversion SHALL be applied after the overflow and blanking decisions, and SHALL also apply to the reset value.
REQ-015 Outputs SHALL NOT depend combinationally on binaryNum; there is no path from the input to the outputs that bypasses the register.

Reset
REQ-016 While rst=1 at a rising clk edge, dec10s and dec1s SHALL load all-segments-off (0000000; 1111111 if ACTIVE_LOW=1).
REQ-017 When rst is deasserted, the first edge with rst=0 SHALL load the conversion of the binaryNum present at that edge.
REQ-018 Reset asserted mid-stream SHALL take priority over conversion at that edge; no prior digit value SHALL persist.
REQ-019 rst SHALL have no asynchronous effect; outputs change only on clk edges.

Verification
REQ-020 Reset held 2 cycles with binaryNum=55 -> dec10s=0000000, dec1s=0000000; after release, the next edge gives 1011011 / 1011011.
REQ-021 Sequence binaryNum 12, 67, 27, 99 on consecutive cycles -> one cycle later each, dec10s/dec1s =
- 0110000 / 1101101
- 1011111 / 1110000
- 1101101 / 1110000
- 1111011 / 1111011
REQ-022 Sweep 0..99, one value per cycle -> each output pair matches the REQ-009 table for tens and ones, delayed by 1 cycle.
REQ-023 binaryNum 100 and 127 -> both outputs 0000001; binaryNum 99 then 100 back-to-back -> 1111011/1111011 followed by 0000001/0000001.
REQ-024 ACTIVE_LOW=1, binaryNum=8 -> dec10s=0000001, dec1s=0000000; BLANK_LZ=1, binaryNum=8 -> dec10s=0000000, dec1s=1111111.
REQ-025 rst pulsed for one cycle between 67 and 27 -> outputs go to 0000000 for exactly that cycle, then 1101101/1110000 on the following edge.

Source files
------------

// File: rtl/bcd_2digit_if.sv
// rtl/bcd_2digit_if.sv - binary input and two-digit 7-segment output bundle for bcd_2digit
interface bcd_2digit_if;
    logic [6:0] binaryNum;
    logic [0:6] dec10s;
    logic [0:6] dec1s;

    modport master (
        output binaryNum,
        input  dec10s,
        input  dec1s
    );

    modport slave (
        input  binaryNum,
        output dec10s,
        output dec1s
    );
endinterface

// File: rtl/bcd_2digit.sv
// rtl/bcd_2digit.sv - registered binary (0..99) to two-digit 7-segment converter
module bcd_2digit #(
    parameter int ACTIVE_LOW = 0,
    parameter int BLANK_LZ   = 0
) (
    input  logic              clk,
    input  logic              rst,
    bcd_2digit_if.slave       bus
);
    localparam logic [0:6] SEG_OFF  = 7'b0000000;
    localparam logic [0:6] SEG_DASH = 7'b0000001;
    localparam logic [0:6] POL      = (ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;

    function automatic logic [0:6] seg7(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Double-dabble; the hundreds carry is shifted out because >=100 shows dashes anyway.
    logic [7:0] bcd;
    always_comb begin
        bcd = 8'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[6:0], bus.binaryNum[i]};
        end
    end

    logic       overflow;
    logic [0:6] next10;
    logic [0:6] next1;

    always_comb begin
        overflow = (bus.binaryNum >= 7'd100);
        next10   = SEG_OFF;
        next1    = SEG_OFF;
        if (overflow) begin
            next10 = SEG_DASH;
            next1  = SEG_DASH;
        end else begin
            next10 = ((BLANK_LZ != 0) && (bcd[7:4] == 4'd0)) ? SEG_OFF : seg7(bcd[7:4]);
            next1  = seg7(bcd[3:0]);
        end
    end

    // Polarity is applied last so reset, dash and blank all honour ACTIVE_LOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dec10s <= POL;
            bus.dec1s  <= POL;
        end else begin
            bus.dec10s <= next10 ^ POL;
            bus.dec1s  <= next1 ^ POL;
        end
    end
endmodule

// File: tb/tb_bcd_2digit.sv
// tb/tb_bcd_2digit.sv - scoreboard bench for bcd_2digit in default, ACTIVE_LOW and BLANK_LZ builds
module tb_bcd_2digit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_2digit_if if_m ();
    bcd_2digit_if if_a ();
    bcd_2digit_if if_b ();

    bcd_2digit #(.ACTIVE_LOW(0), .BLANK_LZ(0)) dut_m (.clk(clk), .rst(rst), .bus(if_m.slave));
    bcd_2digit #(.ACTIVE_LOW(1), .BLANK_LZ(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    bcd_2digit #(.ACTIVE_LOW(0), .BLANK_LZ(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    typedef struct {
        int         tag;
        logic [0:6] m10, m1, a10, a1, b10, b1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [0:6] segtab [10];
    initial begin
        segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
        segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
        segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
        segtab[9] = 7'b1111011;
    end

    task automatic chk(input string name, input int tag, input logic [13:0] act, input logic [13:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s in=%0d actual=%b/%b required=%b/%b", name, tag,
                     act[13:7], act[6:0], req[13:7], req[6:0]);
        end
    endtask

    // Drive one cycle of stimulus and queue what must appear after the next edge.
    task automatic step(input logic r, input logic [6:0] v, input logic [0:6] e10, input logic [0:6] e1);
        exp_t e;
        @(negedge clk);
        rst            = r;
        if_m.binaryNum = v;
        if_a.binaryNum = v;
        if_b.binaryNum = v;
        e.tag = r ? -1 : int'(v);
        if (r) begin
            e.m10 = 7'b0000000; e.m1 = 7'b0000000;
            e.a10 = 7'b1111111; e.a1 = 7'b1111111;
            e.b10 = 7'b0000000; e.b1 = 7'b0000000;
        end else begin
            e.m10 = e10;  e.m1 = e1;
            e.a10 = ~e10; e.a1 = ~e1;
            e.b10 = (v < 7'd10) ? 7'b0000000 : e10;
            e.b1  = e1;
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("main", e.tag, {if_m.dec10s, if_m.dec1s}, {e.m10, e.m1});
                chk("active_low", e.tag, {if_a.dec10s, if_a.dec1s}, {e.a10, e.a1});
                chk("blank_lz", e.tag, {if_b.dec10s, if_b.dec1s}, {e.b10, e.b1});
            end
        end
    end

    initial begin : driver
        if_m.binaryNum = 7'd0;
        if_a.binaryNum = 7'd0;
        if_b.binaryNum = 7'd0;

        step(1'b1, 7'd55, 7'b0, 7'b0);
        step(1'b1, 7'd55, 7'b0, 7'b0);
        step(1'b0, 7'd55, 7'b1011011, 7'b1011011);

        step(1'b0, 7'd12, 7'b0110000, 7'b1101101);
        step(1'b0, 7'd67, 7'b1011111, 7'b1110000);
        step(1'b0, 7'd27, 7'b1101101, 7'b1110000);
        step(1'b0, 7'd99, 7'b1111011, 7'b1111011);

        step(1'b0, 7'd67, 7'b1011111, 7'b1110000);
        step(1'b1, 7'd27, 7'b0, 7'b0);
        step(1'b0, 7'd27, 7'b1101101, 7'b1110000);

        step(1'b0, 7'd99,  7'b1111011, 7'b1111011);
        step(1'b0, 7'd100, 7'b0000001, 7'b0000001);
        step(1'b0, 7'd127, 7'b0000001, 7'b0000001);
        step(1'b0, 7'd8,   7'b1111110, 7'b1111111);
        step(1'b0, 7'd0,   7'b1111110, 7'b1111110);
        step(1'b0, 7'd9,   7'b1111110, 7'b1111011);
        step(1'b0, 7'd10,  7'b0110000, 7'b1111110);

        for (int v = 0; v < 100; v++)
            step(1'b0, 7'(v), segtab[v / 10], segtab[v % 10]);

        step(1'b1, 7'd88, 7'b0, 7'b0);

        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
